// File: rtl/mem_responder.sv
// Memory responder: serves single-word read and write bursts from an
// internal word array after a configurable per-beat latency, with a
// backdoor host port for preload/dump, saturating beat counters and a
// sticky protocol/address error flag.
module mem_responder #(
    parameter int ADDR_WID   = 12,
    parameter int DATA_WID   = 32,
    parameter int WORD_SHIFT = 2,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic                finish_read,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                finish_write,
    output logic [63:0]         write_ready,
    input  logic [63:0]         xfer_size,
    input  logic                host_we,
    input  logic [ADDR_WID-1:0] host_addr,
    input  logic [DATA_WID-1:0] host_wdata,
    output logic [DATA_WID-1:0] host_rdata,
    output logic [31:0]         rd_beats,
    output logic [31:0]         wr_beats,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BEAT,
        RD_ACK,
        WR_WAIT,
        WR_BEAT,
        WR_ACK
    } state_t;

    localparam logic [63:0] STRIDE   = 64'd1 << WORD_SHIFT;
    localparam logic [63:0] LOW_MASK = STRIDE - 64'd1;
    localparam logic [3:0]  RD_LAT_V = 4'(RD_LAT);
    localparam logic [3:0]  WR_LAT_V = 4'(WR_LAT);

    logic [DATA_WID-1:0] mem [2**ADDR_WID];

    state_t              state;
    logic [3:0]          lat_cnt;
    logic                rd_ready_q;
    logic                wr_ready_q;
    logic [ADDR_WID-1:0] rd_idx;
    logic [ADDR_WID-1:0] wr_idx;
    logic                lat_done;
    logic                rd_fire;
    logic                wr_fire;
    logic                size_bad;
    logic                fin_bad;
    logic                beat_bad;

    // An address is bad if it is not word aligned or its word index
    // falls outside the array.
    function automatic logic addr_bad(input logic [63:0] addr);
        return ((addr & LOW_MASK) != 64'd0) ||
               (((addr >> WORD_SHIFT) >> ADDR_WID) != 64'd0);
    endfunction

    assign read_ready  = {63'd0, rd_ready_q};
    assign write_ready = {63'd0, wr_ready_q};

    // Word indices are simply truncated; out-of-range addresses wrap.
    assign rd_idx = ADDR_WID'(read_addr >> WORD_SHIFT);
    assign wr_idx = ADDR_WID'(write_addr >> WORD_SHIFT);

    // The wait ends on the cycle the counter would reach zero, so a
    // latency of N costs N wait cycles (minimum one).
    assign lat_done = (lat_cnt <= 4'd1);
    assign rd_fire  = (state == RD_WAIT) && read_enable  && lat_done;
    assign wr_fire  = (state == WR_WAIT) && write_enable && lat_done;

    // Error sources: stray acknowledgments, and bad address/stride on the
    // edge where a beat is launched.
    assign size_bad = (xfer_size != STRIDE);
    assign fin_bad  = (finish_read  && (state != RD_ACK)) ||
                      (finish_write && (state != WR_ACK));
    assign beat_bad = (rd_fire && (addr_bad(read_addr)  || size_bad)) ||
                      (wr_fire && (addr_bad(write_addr) || size_bad));

    // Burst FSM with registered strobes, read data, counters and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            rd_ready_q <= 1'b0;
            wr_ready_q <= 1'b0;
            read_data  <= '0;
            host_rdata <= '0;
            rd_beats   <= 32'd0;
            wr_beats   <= 32'd0;
            err        <= 1'b0;
        end else begin
            rd_ready_q <= rd_fire;
            wr_ready_q <= wr_fire;
            host_rdata <= mem[host_addr];

            if (rd_fire) begin
                read_data <= mem[rd_idx];
                if (rd_beats != 32'hFFFF_FFFF) begin
                    rd_beats <= rd_beats + 32'd1;
                end
            end
            if (wr_fire && (wr_beats != 32'hFFFF_FFFF)) begin
                wr_beats <= wr_beats + 32'd1;
            end
            if (fin_bad || beat_bad) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (read_enable) begin
                        state   <= RD_WAIT;
                        lat_cnt <= RD_LAT_V;
                    end else if (write_enable) begin
                        state   <= WR_WAIT;
                        lat_cnt <= WR_LAT_V;
                    end
                end
                RD_WAIT: begin
                    if (!read_enable) begin
                        state   <= IDLE;
                        lat_cnt <= 4'd0;
                    end else if (lat_done) begin
                        state   <= RD_BEAT;
                        lat_cnt <= 4'd0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RD_BEAT: begin
                    state <= RD_ACK;
                end
                RD_ACK: begin
                    if (finish_read) begin
                        state   <= RD_WAIT;
                        lat_cnt <= RD_LAT_V;
                    end else if (!read_enable) begin
                        state <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (!write_enable) begin
                        state   <= IDLE;
                        lat_cnt <= 4'd0;
                    end else if (lat_done) begin
                        state   <= WR_BEAT;
                        lat_cnt <= 4'd0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                WR_BEAT: begin
                    state <= WR_ACK;
                end
                WR_ACK: begin
                    if (finish_write) begin
                        state   <= WR_WAIT;
                        lat_cnt <= WR_LAT_V;
                    end else if (!write_enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory array, never reset; the burst write is applied last so it
    // overrides a same-word host write in the same cycle.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        if (wr_fire) begin
            mem[wr_idx] <= write_data;
        end
    end

endmodule
